// File: rtl/sata_bist_lfsr_chk.sv
// sata_bist_lfsr_chk
//   Receive-side checker for the SATA BIST LFSR pattern. It seeds its
//   predictor from received data. It confirms the seed over LOCK_CNT
//   consecutive matches. Once locked, it flywheels the prediction and counts
//   mismatching words until LOSS_CNT consecutive misses drop lock.
//
//   Optional feature macro: BIST_CHK_BITERR_EN adds bit_err_cnt, a saturating
//   per-bit error total over mismatching LOCKED beats.
//
// Ports
//   clk, rst      core clock, asynchronous active-high reset
//   enable        checker active; low forces HUNT and holds the counters
//   clear         synchronous clear of counters and sticky flag
//   rx_valid      qualifies rx_data
//   rx_data       received 32-bit LFSR state word
//   locked        FSM is in LOCKED
//   err_pulse     one-cycle pulse per mismatching word while LOCKED
//   err_cnt       saturating mismatch count
//   word_cnt      saturating count of words checked while LOCKED
//   sync_lost     one-cycle pulse on LOCKED->HUNT due to misses
//   bit_err_cnt   (BIST_CHK_BITERR_EN only) saturating mismatched-bit total
//   err_seen      sticky error flag since reset/clear
module sata_bist_lfsr_chk #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 8,
  parameter int unsigned ERR_W    = 16,
  parameter int unsigned WORD_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              rx_valid,
  input  logic [31:0]       rx_data,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WORD_W-1:0] word_cnt,
  output logic              sync_lost,
`ifdef BIST_CHK_BITERR_EN
  output logic [ERR_W-1:0]  bit_err_cnt,
`endif
  output logic              err_seen
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  // Count thresholds expressed as "last value before the event" so the
  // counters only ever need 8 bits.
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_CNT - 1);

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h0000_00AF : 32'h0);
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        pred_q, pred_d;
  logic [7:0]         match_q, match_d;
  logic [7:0]         miss_q, miss_d;
  logic               err_pulse_q, err_pulse_d;
  logic               sync_lost_q, sync_lost_d;
  logic               err_seen_q, err_seen_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;
  logic               hit;

  assign hit = (rx_data == pred_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      pred_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      sync_lost_q <= 1'b0;
      err_seen_q  <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_pulse_d;
      sync_lost_q <= sync_lost_d;
      err_seen_q  <= err_seen_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    sync_lost_d = 1'b0;
    err_seen_d  = err_seen_q;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;

    if (!enable) begin
      state_d = ST_HUNT;
      match_d = '0;
      miss_d  = '0;
    end else if (rx_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          // All-zero is the LFSR lockup word and can never seed.
          if (rx_data != '0) begin
            pred_d  = lfsr_next(rx_data);
            match_d = '0;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (hit) begin
            pred_d = lfsr_next(rx_data);
            if (match_q == LOCK_LAST) begin
              state_d = ST_LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + 8'd1;
            end
          end else if (rx_data != '0) begin
            pred_d  = lfsr_next(rx_data);
            match_d = '0;
          end else begin
            match_d = '0;
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // Flywheel: prediction advances from itself, never from data.
          pred_d = lfsr_next(pred_q);
          if (word_cnt_q != '1) word_cnt_d = word_cnt_q + WORD_W'(1);
          if (hit) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_seen_d  = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (miss_q == LOSS_LAST) begin
              state_d     = ST_HUNT;
              sync_lost_d = 1'b1;
              miss_d      = '0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // Clear overrides any same-cycle count; err_pulse is left alone.
    if (clear) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
      err_seen_d = 1'b0;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign sync_lost = sync_lost_q;
  assign err_seen  = err_seen_q;
  assign err_cnt   = err_cnt_q;
  assign word_cnt  = word_cnt_q;

`ifdef BIST_CHK_BITERR_EN
  localparam int unsigned SUM_W = ((ERR_W > 6) ? ERR_W : 6) + 1;
  localparam logic [SUM_W-1:0] BE_MAX = SUM_W'({ERR_W{1'b1}});

  logic [31:0]      be_diff;
  logic [5:0]       be_pc;
  logic [5:0]       be_pc_q, be_pc_d;
  logic             be_vld_q, be_vld_d;
  logic [ERR_W-1:0] bit_err_q, bit_err_d;
  logic [SUM_W-1:0] be_sum;

  assign be_diff = rx_data ^ pred_q;

  always_comb begin
    be_pc = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      be_pc = be_pc + 6'(be_diff[i]);
    end
  end

  // Stage 1 captures the popcount of a LOCKED mismatch; stage 2 accumulates.
  // A clear in either stage discards the pending contribution, keeping this
  // total consistent with err_cnt.
  always_comb begin
    be_vld_d  = enable && rx_valid && (state_q == ST_LOCKED) && !hit && !clear;
    be_pc_d   = be_pc;
    be_sum    = SUM_W'(bit_err_q) + SUM_W'(be_pc_q);
    bit_err_d = bit_err_q;
    if (clear) begin
      bit_err_d = '0;
    end else if (be_vld_q) begin
      bit_err_d = (be_sum > BE_MAX) ? '1 : ERR_W'(be_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      be_pc_q   <= '0;
      be_vld_q  <= 1'b0;
      bit_err_q <= '0;
    end else begin
      be_pc_q   <= be_pc_d;
      be_vld_q  <= be_vld_d;
      bit_err_q <= bit_err_d;
    end
  end

  assign bit_err_cnt = bit_err_q;
`endif

endmodule

// File: tb/tb_sata_bist_lfsr_chk.sv
module tb_sata_bist_lfsr_chk;

  localparam int NV = 27;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Instance 1: default parameters
  logic        en, clr, vld;
  logic [31:0] data;
  logic        locked, ep, sl, es;
  logic [15:0] ec;
  logic [31:0] wc;

  // Instance 2: narrow error counter, very tolerant loss threshold
  logic        en2, clr2, vld2;
  logic [31:0] data2;
  logic        locked2, ep2, sl2, es2;
  logic [3:0]  ec2;
  logic [31:0] wc2;

`ifdef BIST_CHK_BITERR_EN
  logic [15:0] be;
  logic [3:0]  be2;
`endif

  sata_bist_lfsr_chk #(.LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(16), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .enable(en), .clear(clr), .rx_valid(vld), .rx_data(data),
    .locked(locked), .err_pulse(ep), .err_cnt(ec), .word_cnt(wc), .sync_lost(sl),
`ifdef BIST_CHK_BITERR_EN
    .bit_err_cnt(be),
`endif
    .err_seen(es)
  );

  sata_bist_lfsr_chk #(.LOCK_CNT(4), .LOSS_CNT(255), .ERR_W(4), .WORD_W(32)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .clear(clr2), .rx_valid(vld2), .rx_data(data2),
    .locked(locked2), .err_pulse(ep2), .err_cnt(ec2), .word_cnt(wc2), .sync_lost(sl2),
`ifdef BIST_CHK_BITERR_EN
    .bit_err_cnt(be2),
`endif
    .err_seen(es2)
  );

  typedef struct {
    logic        en, clr, vld;
    logic [31:0] data;
    logic        l, ep, sl, es;
    logic [15:0] ec;
    logic [31:0] wc;
    logic        cb;
    logic [15:0] be;
  } vec_t;

  vec_t        tbl [NV];
  logic [31:0] w [0:31];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [31:0] nxt(input logic [31:0] s);
    logic [31:0] r;
    r = {s[30:0], 1'b0};
    if (s[31]) r = r ^ 32'h0000_00AF;
    return r;
  endfunction

  function automatic vec_t mk(input logic e, c, v, input logic [31:0] d,
                              input logic l_, ep_, sl_, es_,
                              input logic [15:0] ec_, input logic [31:0] wc_);
    vec_t t;
    t.en = e; t.clr = c; t.vld = v; t.data = d;
    t.l = l_; t.ep = ep_; t.sl = sl_; t.es = es_; t.ec = ec_; t.wc = wc_;
    t.cb = 1'b0; t.be = '0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, c, v, input logic [31:0] d);
    @(negedge clk);
    en = e; clr = c; vld = v; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic e, c, v, input logic [31:0] d);
    @(negedge clk);
    en2 = e; clr2 = c; vld2 = v; data2 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    w[0] = 32'hA544_55D5;
    for (int k = 1; k < 32; k++) w[k] = nxt(w[k-1]);

    //                 en clr vld data          L ep sl es ec wc
    tbl[0]  = mk(1, 0, 1, w[0],          0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 32'h4A88_AB05, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, w[2],          0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, w[3],          0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 1, w[4],          1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 32'h1234_5678, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 1, w[5],          1, 0, 0, 0, 0, 1);
    tbl[7]  = mk(1, 0, 1, w[6] ^ 32'h1,  1, 1, 0, 1, 1, 2);
    tbl[8]  = mk(1, 0, 1, w[7],          1, 0, 0, 1, 1, 3);
    tbl[8].cb = 1'b1; tbl[8].be = 16'd1;
    tbl[9]  = mk(1, 1, 0, 32'h0,         1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      tbl[9+k] = mk(1, 0, 1, ~w[7+k], (k != 8), 1, (k == 8), 1, 16'(k), 32'(k));
    tbl[18] = mk(1, 0, 0, 32'h0,         0, 0, 0, 1, 8, 8);
    for (int j = 0; j < 5; j++)
      tbl[19+j] = mk(1, 0, 1, w[20+j], (j == 4), 0, 0, 1, 8, 8);
    tbl[24] = mk(1, 0, 1, w[25],         1, 0, 0, 1, 8, 9);
    tbl[25] = mk(0, 0, 1, w[26],         0, 0, 0, 1, 8, 9);
    tbl[26] = mk(1, 0, 1, w[27],         0, 0, 0, 1, 8, 9);

    rst = 1'b1;
    en = 1'b1; clr = 1'b0; vld = 1'b0; data = '0;
    en2 = 1'b1; clr2 = 1'b0; vld2 = 1'b0; data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst err_pulse", 32'(ep), 32'd0);
    chk("rst sync_lost", 32'(sl), 32'd0);
    chk("rst err_seen", 32'(es), 32'd0);
    chk("rst err_cnt", 32'(ec), 32'd0);
    chk("rst word_cnt", wc, 32'd0);
    chk("rst2 err_cnt", 32'(ec2), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].data);
      chk($sformatf("r%0d locked", i),    32'(locked), 32'(tbl[i].l));
      chk($sformatf("r%0d err_pulse", i), 32'(ep),     32'(tbl[i].ep));
      chk($sformatf("r%0d sync_lost", i), 32'(sl),     32'(tbl[i].sl));
      chk($sformatf("r%0d err_seen", i),  32'(es),     32'(tbl[i].es));
      chk($sformatf("r%0d err_cnt", i),   32'(ec),     32'(tbl[i].ec));
      chk($sformatf("r%0d word_cnt", i),  wc,          tbl[i].wc);
`ifdef BIST_CHK_BITERR_EN
      if (tbl[i].cb) chk($sformatf("r%0d bit_err_cnt", i), 32'(be), 32'(tbl[i].be));
`endif
    end

    // Zero words never seed: the VERIFY mismatch drops to HUNT, and HUNT holds.
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 1, 32'h0);
      chk($sformatf("zero%0d locked", k), 32'(locked), 32'd0);
    end

    // Two matches, then a mismatch reseeds; four fresh matches are needed.
    step(1, 0, 1, w[0]);
    step(1, 0, 1, w[1]);
    step(1, 0, 1, w[2]);
    step(1, 0, 1, w[10]);
    for (int k = 11; k <= 13; k++) begin
      step(1, 0, 1, w[k]);
      chk($sformatf("reseed w%0d locked", k), 32'(locked), 32'd0);
    end
    step(1, 0, 1, w[14]);
    chk("reseed lock", 32'(locked), 32'd1);
    step(1, 0, 1, w[15]);
    chk("reseed word_cnt", wc, 32'd10);
    chk("reseed err_cnt", 32'(ec), 32'd8);

    // Clear coincident with an error.
    step(1, 1, 1, ~w[16]);
    chk("clr+err err_pulse", 32'(ep), 32'd1);
    chk("clr+err err_cnt", 32'(ec), 32'd0);
    chk("clr+err err_seen", 32'(es), 32'd0);
    chk("clr+err word_cnt", wc, 32'd0);
    step(1, 0, 1, w[17]);
    chk("flywheel err_pulse", 32'(ep), 32'd0);
    chk("flywheel word_cnt", wc, 32'd1);
    chk("flywheel locked", 32'(locked), 32'd1);

    // Asynchronous reset while locked.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async rst locked", 32'(locked), 32'd0);
    chk("async rst word_cnt", wc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;

    // Saturation on the 4-bit error counter.
    for (int k = 0; k < 5; k++) step2(1, 0, 1, w[k]);
    chk("sat lock", 32'(locked2), 32'd1);
    for (int k = 0; k < 20; k++) begin
      step2(1, 0, 1, ~w[5+k]);
      if (k == 14) chk("sat reach15", 32'(ec2), 32'd15);
    end
    chk("sat err_cnt", 32'(ec2), 32'd15);
    chk("sat locked", 32'(locked2), 32'd1);
    chk("sat err_seen", 32'(es2), 32'd1);
    step2(1, 1, 0, 32'h0);
    chk("sat clear err_cnt", 32'(ec2), 32'd0);
    chk("sat clear err_seen", 32'(es2), 32'd0);
    step2(1, 1, 1, ~w[25]);
    chk("sat clr+err pulse", 32'(ep2), 32'd1);
    chk("sat clr+err err_cnt", 32'(ec2), 32'd0);
    chk("sat clr+err err_seen", 32'(es2), 32'd0);
    step2(1, 0, 1, ~w[26]);
    chk("sat resume err_cnt", 32'(ec2), 32'd1);
    chk("sat resume err_seen", 32'(es2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
